execute_stage_fwd: RTL and testbench

Parametrised execute stage with E→M pipeline register, operand forwarding from the M and W stages, and valid/ready flow control. It resolves branches in E and can optionally run an iterative multiplier. It sits between the decode-stage register and the memory stage. Single-cycle ALU ops have a latency of one cycle; multiplies stall the stage until they complete.

---
 rtl/execute_stage_fwd.sv | 208 ++++++++++++++++++++
 tb/tb_execute_stage_fwd.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage_fwd.sv
// Execute stage: forwarding from M/W, ALU, branch resolve, E->M pipeline register.
// Latency: single-cycle ops 1 cycle; multiply XLEN+1 cycles (stage stalls meanwhile).
// Backpressure: ready_E drops while M is full and stalled, or while a multiply runs.
// Optional iterative shift-add multiplier is built only when EXEC_MUL_EN is defined.
module execute_stage_fwd #(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               valid_E,
   output logic               ready_E,
   input  logic               flush_E,
   input  logic               stall_M,
   input  logic [XLEN-1:0]    RD1_E,
   input  logic [XLEN-1:0]    RD2_E,
   input  logic [XLEN-1:0]    ImmExt_E,
   input  logic [XLEN-1:0]    PC_E,
   input  logic [RADDR_W-1:0] Rs1_E,
   input  logic [RADDR_W-1:0] Rs2_E,
   input  logic [RADDR_W-1:0] Rd_E,
   input  logic [2:0]         ALUControl_E,
   input  logic               ALUSrc_E,
   input  logic               RegWrite_E,
   input  logic               MemWrite_E,
   input  logic               ResultSrc_E,
   input  logic               Branch_E,
   input  logic [RADDR_W-1:0] Rd_W,
   input  logic               RegWrite_W,
   input  logic [XLEN-1:0]    Result_W,
   output logic               valid_M,
   output logic               RegWrite_M,
   output logic               MemWrite_M,
   output logic               ResultSrc_M,
   output logic [XLEN-1:0]    AluResult_M,
   output logic [XLEN-1:0]    WriteData_M,
   output logic [RADDR_W-1:0] Rd_M,
   output logic [XLEN-1:0]    PCTarget_E,
   output logic               PCSrc_E
);

   logic [XLEN-1:0] fwd_a;
   logic [XLEN-1:0] fwd_b;
   logic [XLEN-1:0] src_b;
   logic [XLEN-1:0] diff;
   logic [XLEN-1:0] alu_res;
   logic            m_hold;
   logic            xfer;
   logic            single_xfer;
   logic            idle;

   // Operand forwarding: the younger M result wins over W; x0 is never forwarded
   always_comb begin
      if (valid_M && RegWrite_M && (Rd_M != '0) && (Rd_M == Rs1_E))
         fwd_a = AluResult_M;
      else if (RegWrite_W && (Rd_W != '0) && (Rd_W == Rs1_E))
         fwd_a = Result_W;
      else
         fwd_a = RD1_E;

      if (valid_M && RegWrite_M && (Rd_M != '0) && (Rd_M == Rs2_E))
         fwd_b = AluResult_M;
      else if (RegWrite_W && (Rd_W != '0) && (Rd_W == Rs2_E))
         fwd_b = Result_W;
      else
         fwd_b = RD2_E;
   end

   assign src_b = ALUSrc_E ? ImmExt_E : fwd_b;
   assign diff  = fwd_a - src_b;

   // Single-cycle ALU; mul (110) and unused codes yield 0 on this path
   always_comb begin
      alu_res = '0;
      case (ALUControl_E)
         3'b000:  alu_res = fwd_a + src_b;
         3'b001:  alu_res = diff;
         3'b010:  alu_res = fwd_a & src_b;
         3'b011:  alu_res = fwd_a | src_b;
         3'b101:  alu_res = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(src_b))};
         default: alu_res = '0;
      endcase
   end

   assign m_hold     = valid_M & stall_M;
   assign ready_E    = idle & ~m_hold;
   assign xfer       = valid_E & ready_E & ~flush_E;
   assign PCTarget_E = PC_E + ImmExt_E;
   assign PCSrc_E    = xfer & Branch_E & (diff == '0);

`ifdef EXEC_MUL_EN
   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_BUSY = 2'b01;
   localparam logic [1:0] S_DONE = 2'b10;
   localparam int         CW     = $clog2(XLEN);

   logic [1:0]         state;
   logic [CW-1:0]      count;
   logic [XLEN-1:0]    mul_a;
   logic [XLEN-1:0]    mul_b;
   logic [XLEN-1:0]    mul_acc;
   logic [XLEN-1:0]    mul_wd;
   logic [RADDR_W-1:0] mul_rd;
   logic               mul_rw;
   logic               mul_mw;
   logic               mul_rs;
   logic               is_mul;
   logic               mul_load;

   assign is_mul      = (ALUControl_E == 3'b110);
   assign idle        = (state == S_IDLE);
   assign single_xfer = xfer & ~is_mul;
   assign mul_load    = (state == S_DONE) & ~flush_E;

   // Multiplier FSM: latch operands on accept, one shift-add per cycle, hand off in DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         count   <= '0;
         mul_a   <= '0;
         mul_b   <= '0;
         mul_acc <= '0;
         mul_wd  <= '0;
         mul_rd  <= '0;
         mul_rw  <= 1'b0;
         mul_mw  <= 1'b0;
         mul_rs  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (xfer && is_mul) begin
                  state   <= S_BUSY;
                  count   <= '0;
                  mul_a   <= fwd_a;
                  mul_b   <= src_b;
                  mul_acc <= '0;
                  mul_wd  <= fwd_b;
                  mul_rd  <= Rd_E;
                  mul_rw  <= RegWrite_E;
                  mul_mw  <= MemWrite_E;
                  mul_rs  <= ResultSrc_E;
               end
            end
            S_BUSY: begin
               if (flush_E) begin
                  state <= S_IDLE;
               end else begin
                  if (mul_b[0])
                     mul_acc <= mul_acc + mul_a;
                  mul_a <= mul_a << 1;
                  mul_b <= mul_b >> 1;
                  count <= count + 1'b1;
                  if (count == CW'(XLEN-1))
                     state <= S_DONE;
               end
            end
            S_DONE: begin
               // Leaves once the result drains into M, or immediately on flush
               if (flush_E || !m_hold)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
`else
   assign idle        = 1'b1;
   assign single_xfer = xfer;
`endif

   // E->M pipeline register: hold on stall, else load single-cycle op, multiplier result, or bubble
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_M     <= 1'b0;
         RegWrite_M  <= 1'b0;
         MemWrite_M  <= 1'b0;
         ResultSrc_M <= 1'b0;
         AluResult_M <= '0;
         WriteData_M <= '0;
         Rd_M        <= '0;
      end else if (!m_hold) begin
         if (single_xfer) begin
            valid_M     <= 1'b1;
            RegWrite_M  <= RegWrite_E;
            MemWrite_M  <= MemWrite_E;
            ResultSrc_M <= ResultSrc_E;
            AluResult_M <= alu_res;
            WriteData_M <= fwd_b;
            Rd_M        <= Rd_E;
         end
`ifdef EXEC_MUL_EN
         else if (mul_load) begin
            valid_M     <= 1'b1;
            RegWrite_M  <= mul_rw;
            MemWrite_M  <= mul_mw;
            ResultSrc_M <= mul_rs;
            AluResult_M <= mul_acc;
            WriteData_M <= mul_wd;
            Rd_M        <= mul_rd;
         end
`endif
         else begin
            valid_M <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_execute_stage_fwd.sv
// Directed bench for execute_stage_fwd: expected M-stage outputs go into a scoreboard
// queue when an instruction is issued; a negedge monitor pops and compares whenever
// the M register is consumed. Combinational outputs are checked directly.
module tb_execute_stage_fwd;
   localparam int XLEN = 32;
   localparam int RW   = 5;

   logic            clk;
   logic            rst;
   logic            valid_E, ready_E, flush_E, stall_M;
   logic [XLEN-1:0] RD1_E, RD2_E, ImmExt_E, PC_E;
   logic [RW-1:0]   Rs1_E, Rs2_E, Rd_E;
   logic [2:0]      ALUControl_E;
   logic            ALUSrc_E, RegWrite_E, MemWrite_E, ResultSrc_E, Branch_E;
   logic [RW-1:0]   Rd_W;
   logic            RegWrite_W;
   logic [XLEN-1:0] Result_W;
   logic            valid_M, RegWrite_M, MemWrite_M, ResultSrc_M;
   logic [XLEN-1:0] AluResult_M, WriteData_M;
   logic [RW-1:0]   Rd_M;
   logic [XLEN-1:0] PCTarget_E;
   logic            PCSrc_E;

   execute_stage_fwd #(.XLEN(XLEN), .RADDR_W(RW)) dut (
      .clk(clk), .rst(rst), .valid_E(valid_E), .ready_E(ready_E), .flush_E(flush_E),
      .stall_M(stall_M), .RD1_E(RD1_E), .RD2_E(RD2_E), .ImmExt_E(ImmExt_E), .PC_E(PC_E),
      .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E), .ALUControl_E(ALUControl_E),
      .ALUSrc_E(ALUSrc_E), .RegWrite_E(RegWrite_E), .MemWrite_E(MemWrite_E),
      .ResultSrc_E(ResultSrc_E), .Branch_E(Branch_E), .Rd_W(Rd_W), .RegWrite_W(RegWrite_W),
      .Result_W(Result_W), .valid_M(valid_M), .RegWrite_M(RegWrite_M),
      .MemWrite_M(MemWrite_M), .ResultSrc_M(ResultSrc_M), .AluResult_M(AluResult_M),
      .WriteData_M(WriteData_M), .Rd_M(Rd_M), .PCTarget_E(PCTarget_E), .PCSrc_E(PCSrc_E)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [RW-1:0]   rd;
      logic            rw, mw, rs;
      logic [XLEN-1:0] alu, wd;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_err = 0;
   bit   mon_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   // Monitor: an M entry is consumed on an edge where valid_M is set and stall_M is low
   always @(negedge clk) begin
      if (mon_en && !rst && valid_M && !stall_M) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL m_unexpected: got valid_M with AluResult_M 0x%08h, expected no output", AluResult_M);
         end else begin
            mon_e = sb.pop_front();
            check("m_alu",   AluResult_M, mon_e.alu);
            check("m_wdata", WriteData_M, mon_e.wd);
            check("m_rd",    {27'b0, Rd_M}, {27'b0, mon_e.rd});
            check("m_ctrl",  {29'b0, RegWrite_M, MemWrite_M, ResultSrc_M},
                             {29'b0, mon_e.rw, mon_e.mw, mon_e.rs});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] imm, input logic alusrc, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [4:0] rd, input logic rw,
                     input logic mw, input logic rsrc);
      valid_E = 1'b1; ALUControl_E = ctl; RD1_E = a; RD2_E = b; ImmExt_E = imm;
      ALUSrc_E = alusrc; Rs1_E = rs1; Rs2_E = rs2; Rd_E = rd; RegWrite_E = rw;
      MemWrite_E = mw; ResultSrc_E = rsrc; Branch_E = 1'b0; flush_E = 1'b0;
   endtask

   task automatic expect_m(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                           input logic rw, input logic mw, input logic rsrc);
      exp_t e;
      e.alu = alu; e.wd = wd; e.rd = rd; e.rw = rw; e.mw = mw; e.rs = rsrc;
      sb.push_back(e);
   endtask

   task automatic idle_e();
      valid_E = 1'b0; Branch_E = 1'b0; flush_E = 1'b0;
   endtask

   initial begin
      rst = 1'b1; valid_E = 0; flush_E = 0; stall_M = 0; RD1_E = 0; RD2_E = 0;
      ImmExt_E = 0; PC_E = 0; Rs1_E = 0; Rs2_E = 0; Rd_E = 0; ALUControl_E = 0;
      ALUSrc_E = 0; RegWrite_E = 0; MemWrite_E = 0; ResultSrc_E = 0; Branch_E = 0;
      Rd_W = 0; RegWrite_W = 0; Result_W = 0;

      // Reset state, then a mid-cycle asynchronous reset
      tick(); tick();
      check("rst_valid", valid_M, 0);
      check("rst_alu", AluResult_M, 0);
      check("rst_ready", ready_E, 1);
      rst = 1'b0;
      op(3'b000, 5, 6, 0, 0, 20, 21, 1, 1, 1, 1);
      tick();
      check("pre_rst_alu", AluResult_M, 11);
      idle_e();
      #2 rst = 1'b1;
      #1;
      check("async_valid", valid_M, 0);
      check("async_alu", AluResult_M, 0);
      check("async_wd", WriteData_M, 0);
      check("async_rd", {27'b0, Rd_M}, 0);
      check("async_ctrl", {29'b0, RegWrite_M, MemWrite_M, ResultSrc_M}, 0);
      tick();
      rst = 1'b0;
      #1;
      check("ready_after_rst", ready_E, 1);
      mon_en = 1'b1;

      // Forwarding: M beats W; a non-writing M falls through to W; x0 never forwards
      op(3'b000, 3, 4, 0, 0, 1, 2, 5, 1, 0, 0);          expect_m(7, 4, 5, 1, 0, 0);  tick();
      op(3'b000, 100, 100, 0, 0, 5, 5, 6, 1, 0, 0);
      RegWrite_W = 1; Rd_W = 5; Result_W = 9;            expect_m(14, 7, 6, 1, 0, 0); tick();
      RegWrite_W = 0;
      op(3'b000, 3, 4, 0, 0, 1, 2, 5, 0, 0, 0);          expect_m(7, 4, 5, 0, 0, 0);  tick();
      op(3'b000, 100, 100, 0, 0, 5, 5, 6, 1, 0, 0);
      RegWrite_W = 1; Rd_W = 5; Result_W = 9;            expect_m(18, 9, 6, 1, 0, 0); tick();
      RegWrite_W = 0;
      op(3'b000, 1, 1, 0, 0, 20, 21, 0, 1, 0, 0);        expect_m(2, 1, 0, 1, 0, 0);  tick();
      op(3'b000, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0);
      RegWrite_W = 1; Rd_W = 0; Result_W = 55;           expect_m(0, 0, 7, 1, 0, 0);  tick();
      op(3'b001, 50, 100, 0, 0, 20, 8, 9, 1, 0, 0);
      RegWrite_W = 1; Rd_W = 8; Result_W = 20;           expect_m(30, 20, 9, 1, 0, 0); tick();
      RegWrite_W = 0;

      // ALU operations, immediate source, control bit propagation
      op(3'b001, 10, 32'h55, 3, 1, 20, 21, 1, 1, 1, 0);  expect_m(7, 32'h55, 1, 1, 1, 0); tick();
      op(3'b010, 32'hF0F0, 32'h0FF0, 0, 0, 20, 21, 2, 1, 0, 1);
      expect_m(32'h00F0, 32'h0FF0, 2, 1, 0, 1); tick();
      op(3'b011, 32'hF0F0, 32'h0FF0, 0, 0, 20, 21, 3, 1, 0, 0);
      expect_m(32'hFFF0, 32'h0FF0, 3, 1, 0, 0); tick();
      op(3'b101, 32'hFFFF_FFFF, 1, 0, 0, 20, 21, 4, 1, 0, 0); expect_m(1, 1, 4, 1, 0, 0); tick();
      op(3'b101, 1, 32'hFFFF_FFFF, 0, 0, 20, 21, 4, 1, 0, 0);
      expect_m(0, 32'hFFFF_FFFF, 4, 1, 0, 0); tick();
      op(3'b100, 5, 6, 0, 0, 20, 21, 4, 1, 0, 0);        expect_m(0, 6, 4, 1, 0, 0); tick();
      op(3'b111, 5, 6, 0, 0, 20, 21, 4, 1, 0, 0);        expect_m(0, 6, 4, 1, 0, 0); tick();
`ifndef EXEC_MUL_EN
      op(3'b110, 7, 9, 0, 0, 20, 21, 5, 1, 0, 0);        expect_m(0, 9, 5, 1, 0, 0);
      #1 check("mul_off_ready_in", ready_E, 1);
      tick();
      check("mul_off_ready_out", ready_E, 1);
`endif
      idle_e(); tick();
      check("bubble_valid", valid_M, 0);

      // Branch resolution, flush, not-taken
      op(3'b001, 3, 3, 32'h20, 0, 20, 21, 0, 0, 0, 0);
      Branch_E = 1; PC_E = 32'h100;
      #1;
      check("br_taken", PCSrc_E, 1);
      check("br_target", PCTarget_E, 32'h120);
      expect_m(0, 3, 0, 0, 0, 0); tick();
      op(3'b001, 3, 3, 32'h20, 0, 20, 21, 0, 0, 0, 0);
      Branch_E = 1; flush_E = 1;
      #1 check("br_flush_pcsrc", PCSrc_E, 0);
      tick();
      idle_e();
      check("flush_bubble", valid_M, 0);
      op(3'b001, 3, 4, 32'h20, 0, 20, 21, 0, 0, 0, 0);
      Branch_E = 1;
      #1 check("br_not_taken", PCSrc_E, 0);
      expect_m(32'hFFFF_FFFF, 4, 0, 0, 0, 0); tick();
      idle_e(); tick();

      // Stall with a full M register: outputs frozen, E not accepted
      op(3'b000, 1, 2, 0, 0, 20, 21, 3, 1, 0, 0);        expect_m(3, 2, 3, 1, 0, 0); tick();
      op(3'b000, 10, 20, 0, 0, 20, 21, 4, 1, 0, 0);
      stall_M = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_ready", ready_E, 0);
         check("stall_alu", AluResult_M, 3);
         check("stall_valid", valid_M, 1);
         tick();
      end
      stall_M = 0;
      expect_m(30, 20, 4, 1, 0, 0); tick();
      idle_e(); tick();

      // Stall with an empty M register: the register may still fill
      stall_M = 1;
      #1 check("stall_empty_ready", ready_E, 1);
      op(3'b000, 4, 4, 0, 0, 20, 21, 5, 1, 0, 0);        expect_m(8, 4, 5, 1, 0, 0); tick();
      idle_e();
      #1 check("stall_full_ready", ready_E, 0);
      tick();
      stall_M = 0;
      tick(); tick();

`ifdef EXEC_MUL_EN
      // Iterative multiply: low word of the product, XLEN+1 cycles, stage blocked meanwhile
      begin
         int cycles;
         op(3'b110, 32'hFFFF_FFFF, 3, 0, 0, 20, 21, 6, 1, 0, 0);
         expect_m(32'hFFFF_FFFD, 3, 6, 1, 0, 0);
         tick();
         idle_e();
         cycles = 0;
         while (!valid_M && cycles < 40) begin
            check("mul_ready_low", ready_E, 0);
            tick();
            cycles++;
         end
         check("mul_latency", cycles, 33);
         check("mul_ready_after", ready_E, 1);
         tick();
         op(3'b110, 5, 7, 0, 0, 20, 21, 7, 1, 0, 0);
         tick();
         idle_e();
         repeat (9) tick();
         flush_E = 1; tick(); flush_E = 0;
         check("mul_flush_ready", ready_E, 1);
         repeat (40) tick();
      end
`endif

      check("sb_empty", sb.size(), 0);
      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
